// File: rtl/fetch_unit_if.sv
// Bundle between the fetch stage, its program memory and the datapath.
// The master modport is the fetch unit's view of the bundle.
interface fetch_unit_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 15
);
  logic               enable;
  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_data;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_addr;

  modport master (
    input  enable, mem_data, instr_ready, jump_en, jump_addr,
    output mem_rd, mem_addr, instr, instr_pc, instr_valid
  );

  modport slave (
    output enable, mem_data, instr_ready, jump_en, jump_addr,
    input  mem_rd, mem_addr, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a one-cycle-latency program
// memory and presents each word to the datapath over a valid/ready handshake.
module fetch_unit #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 15
) (
  input  logic          clock,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    VALID   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // A jump is only honoured on the accepting VALID cycle, replacing the increment done at capture.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      IDLE: begin
        if (bus.enable) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        instr_d    = bus.mem_data;
        instr_pc_d = pc_q;
        pc_d       = pc_q + ADDR_W'(1);
        state_d    = VALID;
      end
      VALID: begin
        if (bus.instr_ready) begin
          if (bus.jump_en) pc_d = bus.jump_addr;
          state_d = bus.enable ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_rd      = (state_q == ISSUE);
  assign bus.mem_addr    = pc_q;
  assign bus.instr_valid = (state_q == VALID);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a transaction-level PC model
// predicts every fetched word; a negedge monitor checks what the DUT presents.
module tb_fetch_unit;

  logic clock;
  logic reset;

  fetch_unit_if #(.ADDR_W(4), .INSTR_W(15)) bus ();

  fetch_unit #(.ADDR_W(4), .INSTR_W(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [14:0] instr;
    logic [3:0]  pc;
  } exp_t;

  logic [14:0] mem [16];
  exp_t        exp_q [$];
  exp_t        cur;
  int          checks = 0;
  int          fails  = 0;
  bit          sb_on  = 1'b0;
  bit          prev_rd = 1'b0;
  bit          prev_valid = 1'b0;
  int          rd_age = 0;
  logic [3:0]  pc_model;

  // Program memory: data only meaningful the cycle after a read strobe.
  always @(posedge clock) begin
    if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    else            bus.mem_data <= 15'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  task automatic push_fetch(input logic [3:0] pc);
    exp_t e;
    e.instr = mem[pc];
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_valid) begin
        ok = 1'b1;
        return;
      end
      @(posedge clock);
      #2;
    end
    flag("valid_timeout");
  endtask

  // Monitor: every strobe must target the next predicted address; every new presentation is popped and compared.
  always @(negedge clock) begin
    if (sb_on) begin
      if (rd_age < 1000) rd_age++;
      if (bus.mem_rd) begin
        check("rd_single_cycle", 32'(prev_rd), 32'd0);
        check("rd_while_valid", 32'(bus.instr_valid), 32'd0);
        if (exp_q.size() == 0) flag("unexpected_mem_rd");
        else check("mem_addr", 32'(bus.mem_addr), 32'(exp_q[0].pc));
        rd_age = 0;
      end
      if (bus.instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) flag("unexpected_valid");
        else begin
          cur = exp_q.pop_front();
          check("instr", 32'(bus.instr), 32'(cur.instr));
          check("instr_pc", 32'(bus.instr_pc), 32'(cur.pc));
          check("fetch_latency", 32'(rd_age), 32'd2);
        end
      end else if (bus.instr_valid) begin
        check("instr_hold", 32'(bus.instr), 32'(cur.instr));
        check("instr_pc_hold", 32'(bus.instr_pc), 32'(cur.pc));
      end
    end
    prev_rd    = bus.mem_rd;
    prev_valid = bus.instr_valid;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_rd"}, 32'(bus.mem_rd), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_instr"}, 32'(bus.instr), 32'd0);
    check({tag, "_instr_pc"}, 32'(bus.instr_pc), 32'd0);
    check({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
  endtask

  task automatic applyStimulus();
    bit ok;
    bit do_jump;
    bit en;
    logic [3:0] addr;
    for (int t = 0; t < 60; t++) begin
      wait_valid(ok);
      if (!ok) return;
      repeat ($urandom_range(0, 5)) begin
        bus.instr_ready = 1'b0;
        bus.jump_en     = 1'($urandom_range(0, 1));
        bus.jump_addr   = 4'($urandom);
        bus.enable      = 1'($urandom_range(0, 1));
        @(posedge clock);
        #2;
      end
      do_jump = (t == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
      addr    = (t == 1) ? 4'hE : 4'($urandom);
      en      = (t < 4) ? 1'b1 : ($urandom_range(0, 4) != 0);
      bus.instr_ready = 1'b1;
      bus.jump_en     = do_jump;
      bus.jump_addr   = addr;
      bus.enable      = en;
      pc_model = do_jump ? addr : pc_model + 4'd1;
      if (en) push_fetch(pc_model);
      @(posedge clock);
      #2;
      bus.instr_ready = 1'b0;
      bus.jump_en     = 1'($urandom_range(0, 1));
      bus.jump_addr   = 4'($urandom);
      if (!en) begin
        bus.enable = 1'b0;
        repeat ($urandom_range(1, 4)) begin
          @(posedge clock);
          #2;
          bus.jump_en   = 1'($urandom_range(0, 1));
          bus.jump_addr = 4'($urandom);
        end
        push_fetch(pc_model);
        bus.enable = 1'b1;
      end else begin
        bus.enable = 1'($urandom_range(0, 1));
      end
    end
    wait_valid(ok);
  endtask

  task automatic checkOutput();
    repeat (2) begin
      @(posedge clock);
      #2;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit ok;
    mem[0] = 15'h0011;
    mem[1] = 15'h2222;
    mem[2] = 15'h4333;
    mem[3] = 15'h6444;
    for (int i = 4; i < 16; i++) mem[i] = 15'($urandom);
    reset           = 1'b0;
    bus.enable      = 1'b0;
    bus.instr_ready = 1'b0;
    bus.jump_en     = 1'b0;
    bus.jump_addr   = '0;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");

    @(negedge clock);
    reset           = 1'b1;
    bus.enable      = 1'b1;
    bus.instr_ready = 1'b1;
    wait_valid(ok);
    check("first_instr", 32'(bus.instr), 32'h0011);
    check("first_pc", 32'(bus.instr_pc), 32'd0);

    // Accepted at the next edge, then ISSUE, then CAPTURE of the fetch from pc 1.
    @(posedge clock);
    @(posedge clock);
    #2;
    check("capture_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("capture_mem_addr", 32'(bus.mem_addr), 32'd1);
    reset           = 1'b0;
    bus.enable      = 1'b0;
    bus.instr_ready = 1'b0;
    #1;
    check_reset_outputs("midfetch_reset");
    @(posedge clock);
    #2;
    check("held_reset_valid", 32'(bus.instr_valid), 32'd0);

    reset    = 1'b1;
    pc_model = 4'd0;
    sb_on    = 1'b1;
    push_fetch(pc_model);
    bus.enable = 1'b1;
    applyStimulus();
    checkOutput();

    $display("[TB] %0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the CPU datapath (mux / ALU / register file). It owns the program counter, reads 15-bit instruction words from a synchronous program memory with one-cycle read latency, and presents each word to the datapath through a valid/ready handshake. It supports sequential fetch with wrap-around and an absolute jump applied at the moment an instruction is accepted.

## Interface
- ADDR_W, 4, program counter / memory address width (memory depth 2^ADDR_W)
- INSTR_W, 15, instruction word width ([14:13] opcode, [12:11] read2, [10:9] read1, [8] write_en, [7:6] write addr, [5:4] mux sel, [3:0] immediate)

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run request; fetching starts or continues while high
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_data  in  INSTR_W  memory read data, valid the cycle after mem_rd
- instr  out  INSTR_W  held instruction word
- instr_pc  out  ADDR_W  address the held instruction was fetched from
- instr_valid  out  1  instr/instr_pc are valid
- instr_ready  in  1  datapath accepts instr this cycle
- jump_en  in  1  redirect PC when the current instruction is accepted
- jump_addr  in  ADDR_W  redirect target

## Operation
- Registers: pc (ADDR_W), instr, instr_pc, 2-bit state.
- States: IDLE, ISSUE, CAPTURE, VALID.
- IDLE: mem_rd=0, instr_valid=0. enable=1 -> ISSUE; else stay.
- ISSUE: mem_rd=1, mem_addr=pc. Unconditionally -> CAPTURE.
- CAPTURE: mem_rd=0. At the edge: instr<=mem_data, instr_pc<=pc, pc<=pc+1 (modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0) -> VALID.
- VALID: instr_valid=1; instr, instr_pc stable. On an edge with instr_ready=1: if jump_en=1 then pc<=jump_addr (overrides the increment); next state ISSUE if enable=1, else IDLE. instr_ready=0: stay, outputs unchanged.
- jump_en is ignored in every state except a VALID cycle with instr_ready=1.
- enable deasserted during ISSUE/CAPTURE: transaction completes to VALID; enable is checked again only at handshake.
- enable deasserted in VALID without ready: instruction remains presented; no new fetch after acceptance.
- mem_addr outside ISSUE equals pc (don't-care for memory, but driven, never X).
- Reset (reset=0, any state, including mid-fetch): immediately state=IDLE, pc=0, instr=0, instr_pc=0, instr_valid=0, mem_rd=0. An in-flight read is discarded.

## Timing
- Reset values: mem_rd=0, mem_addr=0, instr=0, instr_pc=0, instr_valid=0.
- Startup latency: enable sampled high in IDLE at edge E0 -> mem_rd high during E0..E1 -> data captured at E2 -> instr_valid high after E2 (2 cycles from enable edge).
- Steady-state: with enable=1 and instr_ready=1 held, one instruction accepted every 3 cycles (VALID, ISSUE, CAPTURE).
- Jump: the instruction fetched after a jump handshake is read from jump_addr in the immediately following ISSUE cycle; no wasted fetch.
- All outputs are registered or decoded from state only; no combinational path from instr_ready/jump_en/enable to any output.

## Test plan
- Reset mid-fetch: memory[0..3]=15'h0011,15'h2222,15'h4333,15'h6444; enable=1, ready=1; assert reset during a CAPTURE cycle -> all outputs 0 immediately, state IDLE; after release first instr=15'h0011, instr_pc=0.
- Sequential fetch: enable=1, ready=1 from reset -> instr sequence 0011, 2222, 4333, 6444 with instr_pc 0,1,2,3; instr_valid every third cycle; mem_rd high exactly one cycle per fetch.
- Backpressure: ready=0 for 5 cycles while valid -> instr/instr_pc held, no mem_rd; ready=1 -> next fetch from pc+1.
- Jump: on handshake of instr_pc=1, jump_en=1, jump_addr=4'hE -> next mem_addr=4'hE, instr_pc=14, then 15, then wraps to 0; jump_en asserted with ready=0 -> no effect.
- Wrap-around: start at pc=15 via jump -> instr_pc=15 followed by instr_pc=0.
- Enable drop: deassert enable during ISSUE -> that instruction still becomes valid; after acceptance state IDLE, mem_rd stays 0; re-assert enable -> fetch resumes at the next sequential address.
